// File: rtl/rom_sprite_blit.sv
// rom_sprite_blit: overlays a ROM-stored RGB565 sprite on the VGA background stream.
// Two-stage pipeline: stage 1 does the hit test and ROM address; stage 2 aligns
// the hit flag and background with the synchronous ROM output. pix_data_out for
// a pixel appears two clocks after its pix_x/pix_y/bg_data.
// Ports:
//   vga_clk, sys_rst_n      pixel clock, async active-low reset
//   pix_x, pix_y, bg_data   requested pixel and its background colour
//   pos_x, pos_y, scale,    sprite placement, captured by cfg_load into a pending
//   mirror, cfg_load        set and made active at the end of the visible frame
//   key_en, key_color       colour-key transparency
//   anim_en                 automatic animation frame advance
//   rom_addr, rom_rden      registered ROM request
//   rom_data                ROM word, one cycle after the request
//   pix_data_out            composited colour
module rom_sprite_blit #(
  parameter int H_VALID  = 640,
  parameter int V_VALID  = 480,
  parameter int PIC_W    = 100,
  parameter int PIC_H    = 100,
  parameter int FRAMES   = 4,
  parameter int ADDR_W   = 16,
  parameter int ANIM_DIV = 8
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [15:0]       bg_data,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale,
  input  logic              mirror,
  input  logic              key_en,
  input  logic [15:0]       key_color,
  input  logic              anim_en,
  input  logic              cfg_load,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rden,
  input  logic [15:0]       rom_data,
  output logic [15:0]       pix_data_out
);

  localparam int STAGES = 2;
  localparam int FIDX_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int ACNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(PIC_W * PIC_H);
  localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(PIC_W);

  typedef struct packed {
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] scale;
    logic       mirror;
  } cfg_t;

  cfg_t cfg_in, cfg_pend, cfg_act;
  logic commit;

  assign cfg_in = {pos_x, pos_y, scale, mirror};
  // Last visible pixel of the frame: the only point the active set may change.
  assign commit = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cfg_pend <= '0;
      cfg_act  <= '0;
    end else begin
      if (cfg_load) cfg_pend <= cfg_in;
      // A load on the commit cycle bypasses the pending register.
      if (commit) cfg_act <= cfg_load ? cfg_in : cfg_pend;
    end
  end

  // Animation: frame_idx steps once every ANIM_DIV commits while enabled.
  logic [FIDX_W-1:0] frame_idx;
  logic [ACNT_W-1:0] anim_cnt;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_idx <= '0;
      anim_cnt  <= '0;
    end else if (commit && anim_en) begin
      if (anim_cnt == ACNT_W'(ANIM_DIV - 1)) begin
        anim_cnt  <= '0;
        frame_idx <= (frame_idx == FIDX_W'(FRAMES - 1)) ? '0 : frame_idx + FIDX_W'(1);
      end else begin
        anim_cnt <= anim_cnt + ACNT_W'(1);
      end
    end
  end

  // Hit test and texel coordinates, all 11-bit so the sum pos+size never wraps.
  logic [1:0]  sft;
  logic [10:0] dx, dy, sw, sh, col_raw, col, row;
  logic        hit;

  always_comb begin
    case (cfg_act.scale)
      2'd0:    sft = 2'd0;
      2'd1:    sft = 2'd1;
      default: sft = 2'd2;
    endcase
  end

  assign dx      = {1'b0, pix_x} - {1'b0, cfg_act.pos_x};
  assign dy      = {1'b0, pix_y} - {1'b0, cfg_act.pos_y};
  assign sw      = 11'(PIC_W) << sft;
  assign sh      = 11'(PIC_H) << sft;
  assign col_raw = dx >> sft;
  assign row     = dy >> sft;
  assign col     = cfg_act.mirror ? (11'(PIC_W - 1) - col_raw) : col_raw;

  assign hit = (pix_x >= cfg_act.pos_x) && (dx < sw) &&
               (pix_y >= cfg_act.pos_y) && (dy < sh) &&
               ({1'b0, pix_x} < 11'(H_VALID)) && ({1'b0, pix_y} < 11'(V_VALID));

  // vld_pipe[n] is the hit flag after n register stages.
  logic [STAGES:1] vld_pipe;
  logic [15:0]     bg_d1, bg_d2;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe <= '0;
      bg_d1    <= '0;
      bg_d2    <= '0;
      rom_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], hit};
      bg_d1    <= bg_data;
      bg_d2    <= bg_d1;
      // Address holds on misses so the ROM bus stays quiet outside the sprite.
      if (hit)
        rom_addr <= ADDR_W'(frame_idx) * FRAME_SZ + ADDR_W'(row) * ROW_SZ + ADDR_W'(col);
    end
  end

  assign rom_rden = vld_pipe[1];

  logic keyed;
  assign keyed        = key_en && (rom_data == key_color);
  assign pix_data_out = (vld_pipe[2] && !keyed) ? rom_data : bg_d2;

endmodule

// File: tb/tb_rom_sprite_blit.sv
// Scoreboard bench for rom_sprite_blit: each tagged pixel pushes its expected
// rom_rden/rom_addr (checked one cycle later) and pix_data_out (two cycles later).
module tb_rom_sprite_blit;
  logic              vga_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [9:0]        pix_x = '0, pix_y = '0, pos_x = '0, pos_y = '0;
  logic [15:0]       bg_data = '0, key_color = '0, rom_data = '0;
  logic [1:0]        scale = '0;
  logic              mirror = 1'b0, key_en = 1'b0, anim_en = 1'b0, cfg_load = 1'b0;
  logic [15:0]       rom_addr;
  logic              rom_rden;
  logic [15:0]       pix_data_out;

  rom_sprite_blit #(.ANIM_DIV(2)) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .bg_data(bg_data), .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .mirror(mirror),
    .key_en(key_en), .key_color(key_color), .anim_en(anim_en), .cfg_load(cfg_load),
    .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_data(rom_data),
    .pix_data_out(pix_data_out)
  );

  always #20 vga_clk = ~vga_clk;

  logic [15:0] rom_mem [0:65535];
  always @(posedge vga_clk) if (rom_rden) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic        rden;
    logic [15:0] addr;
    logic [15:0] pix;
  } exp_t;

  exp_t        rq[$], pq[$];
  int          total = 0, bad = 0;
  logic        cur_tag = 1'b0, tag_d0 = 1'b0;
  logic [15:0] last_addr = '0;

  function automatic logic [15:0] bgc(input int x, input int y);
    return 16'hC000 | 16'((x % 128) * 128 + (y % 128));
  endfunction

  // Monitor: runs on the falling edge, before the driver updates inputs.
  always @(negedge vga_clk) begin
    exp_t e;
    if (tag_d0) begin
      total++;
      if (pq.size() == 0) begin
        bad++; $display("FAIL pix queue empty");
      end else begin
        e = pq.pop_front();
        if (pix_data_out !== e.pix) begin
          bad++; $display("FAIL pix_data_out got %h want %h", pix_data_out, e.pix);
        end
      end
    end
    if (cur_tag) begin
      total += 2;
      if (rq.size() == 0) begin
        bad++; $display("FAIL req queue empty");
      end else begin
        e = rq.pop_front();
        if (rom_rden !== e.rden) begin
          bad++; $display("FAIL rom_rden got %b want %b", rom_rden, e.rden);
        end
        if (rom_addr !== e.addr) begin
          bad++; $display("FAIL rom_addr got %0d want %0d", rom_addr, e.addr);
        end
      end
    end
    tag_d0 = cur_tag;
  end

  task automatic px(input int x, input int y, input bit chk, input bit rd,
                    input logic [15:0] a, input logic [15:0] p);
    exp_t e;
    @(negedge vga_clk); #1;
    pix_x = 10'(x); pix_y = 10'(y); bg_data = bgc(x, y); cfg_load = 1'b0; cur_tag = chk;
    if (chk) begin
      e.rden = rd; e.addr = a; e.pix = p;
      rq.push_back(e); pq.push_back(e);
    end
  endtask

  task automatic hit_p(input int x, input int y, input int a, input logic [15:0] p);
    px(x, y, 1'b1, 1'b1, 16'(a), p);
    last_addr = 16'(a);
  endtask

  task automatic hit(input int x, input int y, input int a);
    hit_p(x, y, a, 16'(a));
  endtask

  task automatic miss(input int x, input int y);
    px(x, y, 1'b1, 1'b0, last_addr, bgc(x, y));
  endtask

  task automatic idle();
    px(1000, 1000, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic drain();
    repeat (3) idle();
  endtask

  task automatic set_cfg(input int x, input int y, input int sc, input bit mir);
    @(negedge vga_clk); #1;
    pos_x = 10'(x); pos_y = 10'(y); scale = 2'(sc); mirror = mir; cfg_load = 1'b1;
    pix_x = 10'd1000; pix_y = 10'd1000; cur_tag = 1'b0;
  endtask

  task automatic commit();
    px(639, 479, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
  endtask

  task automatic test_reset();
    pix_x = 10'd0; pix_y = 10'd0; bg_data = 16'h1234;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    total += 3;
    if (pix_data_out !== 16'h0) begin bad++; $display("FAIL reset_pix got %h want 0000", pix_data_out); end
    if (rom_rden !== 1'b0) begin bad++; $display("FAIL reset_rden got %b want 0", rom_rden); end
    if (rom_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
    #1; pix_x = 10'd1000; pix_y = 10'd1000; sys_rst_n = 1'b1;
    last_addr = '0;
    hit(5, 3, 305);      // reset config: pos 0,0, 1x, no mirror, frame 0
    miss(100, 0);
    drain();
  endtask

  task automatic test_basic();
    set_cfg(270, 190, 0, 1'b0); commit();
    hit(270, 190, 0); hit(369, 190, 99); miss(370, 190); miss(269, 190);
    hit(300, 289, 9930); miss(300, 290); hit(271, 191, 101);
    drain();
  endtask

  task automatic test_scale();
    set_cfg(0, 0, 1, 1'b0); commit();
    hit(0, 0, 0); hit(1, 1, 0); hit(2, 0, 1); hit(199, 199, 9999);
    miss(200, 0); miss(0, 200); hit(3, 5, 201);
    set_cfg(0, 0, 2, 1'b0); commit();
    hit(3, 3, 0); hit(4, 0, 1); hit(399, 399, 9999); miss(400, 0);
    set_cfg(0, 0, 3, 1'b0); commit();
    hit(4, 4, 101); miss(400, 5);
    drain();
  endtask

  task automatic test_mirror();
    set_cfg(0, 0, 0, 1'b1); commit();
    hit(0, 0, 99); hit(99, 0, 0); hit(10, 2, 289); miss(100, 0);
    drain();
  endtask

  task automatic test_edge();
    set_cfg(600, 450, 0, 1'b0); commit();
    miss(599, 450); hit(600, 450, 0); hit(639, 479, 2939);
    miss(640, 479); miss(700, 460); miss(620, 480); miss(620, 600); miss(50, 460);
    drain();
  endtask

  task automatic test_key();
    set_cfg(0, 0, 0, 1'b0); commit();
    rom_mem[5] = 16'hF81F; key_color = 16'hF81F; key_en = 1'b1;
    hit_p(5, 0, 5, bgc(5, 0)); hit(6, 0, 6);
    drain(); key_en = 1'b0;
    hit_p(5, 0, 5, 16'hF81F);
    drain(); key_en = 1'b1; key_color = 16'h0006;
    hit_p(6, 0, 6, bgc(6, 0)); hit_p(5, 0, 5, 16'hF81F);
    drain(); key_en = 1'b0; rom_mem[5] = 16'd5;
  endtask

  task automatic test_midframe_cfg();
    set_cfg(50, 0, 0, 1'b0);
    hit(5, 0, 5); hit(55, 0, 55);           // still the old active set
    commit();
    miss(5, 0); hit(55, 0, 5);
    // Load on the commit cycle itself: the loaded value wins over pending.
    @(negedge vga_clk); #1;
    pos_x = 10'd20; pos_y = 10'd0; scale = 2'd0; mirror = 1'b0; cfg_load = 1'b1;
    pix_x = 10'd639; pix_y = 10'd479; cur_tag = 1'b0;
    idle();
    hit(25, 0, 5); hit(55, 0, 35); miss(15, 0);
    drain();
  endtask

  task automatic test_anim();
    set_cfg(0, 0, 0, 1'b0); commit();
    anim_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      hit(5, 0, ((k / 2) % 4) * 10000 + 5);
      commit();
    end
    anim_en = 1'b0;
    commit(); commit();
    hit(5, 0, 10005);                      // held at frame 1 while disabled
    drain();
  endtask

  task automatic test_reset_midline();
    px(5, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge vga_clk); @(posedge vga_clk); #2;
    total++;
    if (pix_data_out !== 16'd10005) begin bad++; $display("FAIL pre_reset_pix got %h want %h", pix_data_out, 16'd10005); end
    sys_rst_n = 1'b0; #1;
    total += 3;
    if (pix_data_out !== 16'h0) begin bad++; $display("FAIL midline_reset_pix got %h want 0000", pix_data_out); end
    if (rom_rden !== 1'b0) begin bad++; $display("FAIL midline_reset_rden got %b want 0", rom_rden); end
    if (rom_addr !== 16'h0) begin bad++; $display("FAIL midline_reset_addr got %0d want 0", rom_addr); end
    repeat (2) @(posedge vga_clk);
    total++;
    if (pq.size() != 0) begin bad++; $display("FAIL scoreboard_left got %0d want 0", pq.size()); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom_mem[i] = 16'(i);
    test_reset();
    test_basic();
    test_scale();
    test_mirror();
    test_edge();
    test_key();
    test_midframe_cfg();
    test_anim();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
